// File: rtl/vga_pkg.sv
// vga_pkg: shared 1440x900@60 raster timing constants and types for the generator and renderers.
package vga_pkg;
  localparam int COORD_W = 11;
  localparam int VGA_H_ACTIVE = 1440;
  localparam int VGA_H_FP = 80;
  localparam int VGA_H_SYNC = 152;
  localparam int VGA_H_BP = 232;
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_ACTIVE = 900;
  localparam int VGA_V_FP = 1;
  localparam int VGA_V_SYNC = 3;
  localparam int VGA_V_BP = 28;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam bit VGA_H_POL = 1'b0;
  localparam bit VGA_V_POL = 1'b1;
  localparam int VGA_SYNC_DLY = 2;
  typedef logic [COORD_W-1:0] coord_t;
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } sync_t;
  function automatic logic in_win(coord_t v, coord_t lo, coord_t hi);
    return v >= lo && v < hi;
  endfunction
endpackage

// File: rtl/sig_delay.sv
// sig_delay: W-bit shift-register delay of DEPTH stages, async reset loads rst_val into every stage.
module sig_delay #(
  parameter int W = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    logic unused;
    assign unused = ^{clk, rst, rst_val};
    assign q = d;
  end else begin : g_sr
    logic [W-1:0] sr [DEPTH];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= rst_val;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, sync/active decode aligned to renderer latency, line/frame strobes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter bit H_POL = VGA_H_POL,
  parameter bit V_POL = VGA_V_POL,
  parameter int SYNC_DLY = VGA_SYNC_DLY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               active,
  output logic               hsync,
  output logic               vsync,
  output logic               line_tick,
  output logic               frame_tick
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t X_LAST = COORD_W'(H_TOTAL - 1);
  localparam coord_t Y_LAST = COORD_W'(V_TOTAL - 1);
  localparam coord_t X_ACT = COORD_W'(H_ACTIVE);
  localparam coord_t Y_ACT = COORD_W'(V_ACTIVE);
  localparam coord_t HS_B = COORD_W'(H_ACTIVE + H_FP);
  localparam coord_t HS_E = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_B = COORD_W'(V_ACTIVE + V_FP);
  localparam coord_t VS_E = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counter range");
  end
  if (SYNC_DLY < 0 || SYNC_DLY > 7) begin : g_bad_dly
    $error("vga_timing_gen: SYNC_DLY must be 0..7");
  end
  logic x_wrap, y_wrap;
  sync_t raw, idle, dly;
  assign x_wrap = pos_x == X_LAST;
  assign y_wrap = pos_y == Y_LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pos_x <= '0;
      pos_y <= '0;
      line_tick <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      line_tick <= en && x_wrap;
      frame_tick <= en && x_wrap && y_wrap;
      if (en) begin
        pos_x <= x_wrap ? '0 : pos_x + 1'b1;
        if (x_wrap) pos_y <= y_wrap ? '0 : pos_y + 1'b1;
      end
    end
  // Reset forces the idle levels so a zero-depth delay still shows deasserted outputs.
  always_comb begin
    idle = '{act: 1'b0, hs: !H_POL, vs: !V_POL};
    raw = rst ? idle : '{act: pos_x < X_ACT && pos_y < Y_ACT,
                         hs: in_win(pos_x, HS_B, HS_E) ? H_POL : !H_POL,
                         vs: in_win(pos_y, VS_B, VS_E) ? V_POL : !V_POL};
  end
  sig_delay #(.W(3), .DEPTH(SYNC_DLY)) u_dly (
    .clk(clk),
    .rst(rst),
    .rst_val(idle),
    .d(raw),
    .q(dly)
  );
  assign active = dly.act;
  assign hsync = dly.hs;
  assign vsync = dly.vs;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of full-size timing plus reduced-geometry instances for frame-level behaviour.
module tb_vga_timing_gen;
  logic clk = 1'b0, rst, rst_s, en, en_s;
  logic [10:0] x, y, sx, sy, fx, fy;
  logic act, hs, vs, lt, ft;
  logic s_act, s_hs, s_vs, s_lt, s_ft;
  logic f_act, f_hs, f_vs, f_lt, f_ft;
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .en(en), .pos_x(x), .pos_y(y), .active(act),
    .hsync(hs), .vsync(vs), .line_tick(lt), .frame_tick(ft)
  );
  // 16x8 raster: hs on x 10..12, vs on lines 5..6
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .SYNC_DLY(0)) dut_s (
    .clk(clk), .rst(rst_s), .en(en_s), .pos_x(sx), .pos_y(sy), .active(s_act),
    .hsync(s_hs), .vsync(s_vs), .line_tick(s_lt), .frame_tick(s_ft)
  );
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .SYNC_DLY(5)) dut_f (
    .clk(clk), .rst(rst_s), .en(en_s), .pos_x(fx), .pos_y(fy), .active(f_act),
    .hsync(f_hs), .vsync(f_vs), .line_tick(f_lt), .frame_tick(f_ft)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int lt_n, ft_n, act_n, hs_n, vs_n, hs_first, wait_n;
    int slt, sft, sact, shs, svs, flt, fft, fact;
    rst = 1'b0; rst_s = 1'b0; en = 1'b1; en_s = 1'b1;
    #1 rst = 1'b1; rst_s = 1'b1;
    #2;
    chk("rst_x", x, 0); chk("rst_y", y, 0); chk("rst_lt", lt, 0); chk("rst_ft", ft, 0);
    chk("rst_act", act, 0); chk("rst_hs", hs, 1); chk("rst_vs", vs, 0);
    chk("rst_s_act", s_act, 0); chk("rst_s_hs", s_hs, 1); chk("rst_s_vs", s_vs, 0);
    step(2);
    rst = 1'b0;
    lt_n = 0; ft_n = 0; act_n = 0; hs_n = 0; vs_n = 0; hs_first = -1;
    for (int k = 1; k <= 1904; k++) begin
      step(1);
      if (k == 1) chk("x_first", x, 1);
      if (k == 1903) begin chk("x_last", x, 1903); chk("y_line0", y, 0); end
      lt_n += int'(lt); ft_n += int'(ft); act_n += int'(act);
      hs_n += int'(!hs); vs_n += int'(vs);
      if (!hs && hs_first < 0) hs_first = int'(x);
    end
    chk("wrap_x", x, 0); chk("wrap_y", y, 1); chk("wrap_lt", lt, 1);
    chk("line_lt_cnt", lt_n, 1); chk("line_ft_cnt", ft_n, 0); chk("line_act_cnt", act_n, 1440);
    chk("line_hs_cnt", hs_n, 152); chk("hs_start_x", hs_first, 1522); chk("line_vs_cnt", vs_n, 0);
    step(1903);
    chk("pre_freeze_x", x, 1903);
    en = 1'b0;
    lt_n = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      lt_n += int'(lt);
    end
    chk("freeze_x", x, 1903); chk("freeze_y", y, 1); chk("freeze_lt", lt_n, 0);
    chk("freeze_hs", hs, 1); chk("freeze_act", act, 0);
    en = 1'b1;
    step(1);
    chk("thaw_x", x, 0); chk("thaw_y", y, 2); chk("thaw_lt", lt, 1);
    step(1);
    chk("thaw_lt_once", lt, 0);
    wait_n = 0;
    while (x != 11'd1439 && wait_n < 3000) begin step(1); wait_n++; end
    chk("seek_1439", x, 1439);
    step(2);
    chk("d2_act_1439", act, 1);
    step(1);
    chk("d2_act_1440", act, 0);
    wait_n = 0;
    while (x != 11'd1520 && wait_n < 3000) begin step(1); wait_n++; end
    chk("seek_1520", x, 1520);
    step(1);
    chk("d2_hs_pre", hs, 1);
    step(1);
    chk("d2_hs_on", hs, 0);

    rst_s = 1'b0;
    slt = 0; sft = 0; sact = 0; shs = 0; svs = 0; flt = 0; fft = 0; fact = 0;
    for (int k = 1; k <= 384; k++) begin
      step(1);
      slt += int'(s_lt); sft += int'(s_ft); sact += int'(s_act);
      shs += int'(!s_hs); svs += int'(s_vs);
      flt += int'(f_lt); fft += int'(f_ft); fact += int'(f_act);
    end
    chk("s_ft_cnt", sft, 3); chk("s_lt_cnt", slt, 24); chk("s_act_cnt", sact, 96);
    chk("s_hs_cnt", shs, 72); chk("s_vs_cnt", svs, 96);
    chk("f_ft_cnt", fft, 3); chk("f_lt_cnt", flt, 24); chk("f_act_cnt", fact, 96);
    chk("s_frame_x", sx, 0); chk("s_frame_y", sy, 0); chk("s_frame_ft", s_ft, 1);
    step(55);
    chk("s_x7", sx, 7); chk("s_y3", sy, 3); chk("d0_act_last", s_act, 1);
    step(1);
    chk("d0_act_off", s_act, 0); chk("d5_act_mid", f_act, 1);
    step(4);
    chk("d5_act_last", f_act, 1);
    step(1);
    chk("d5_act_off", f_act, 0);
    step(18);
    chk("s_vs_pre", s_vs, 0);
    step(1);
    chk("s_vs_on", s_vs, 1); chk("s_vs_x0", sx, 0); chk("s_vs_y5", sy, 5);
    step(21);
    chk("s_mid_x", sx, 5); chk("s_mid_y", sy, 6); chk("f_vs_mid", f_vs, 1);
    rst_s = 1'b1;
    #1;
    chk("arst_x", sx, 0); chk("arst_y", sy, 0); chk("arst_vs", s_vs, 0);
    chk("arst_hs", s_hs, 1); chk("arst_act", s_act, 0); chk("arst_f_vs", f_vs, 0);
    step(1);
    rst_s = 1'b0;
    svs = 0;
    for (int k = 1; k <= 79; k++) begin
      step(1);
      svs += int'(s_vs);
    end
    chk("rel_vs_cnt", svs, 0); chk("rel_x", sx, 15); chk("rel_y", sy, 4);
    step(1);
    chk("rel_vs_on", s_vs, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
